hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. Watches the instruction held in the IF/ID pipeline register against the EX and MEM stages, and drives four controls: PC write-enable, IF/ID write-enable, IF/ID flush, and ID/EX bubble insertion. Multi-cycle stalls are sequenced by a small FSM with a down-counter. Two saturating event counters are kept for performance debug.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_detect.sv | 35 +++
 rtl/hazard_ctrl.sv | 97 +++++++++
 tb/tb_hazard_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the MIPS hazard controller: FSM states, opcodes, NOP pattern.
package hazard_pkg;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0]  NOP_CTR   = 6'b111111;
  localparam logic [31:0] NOP_INSTR = 32'hFC000000;

  // $0 is hardwired to zero, so a write to it can never create a dependence.
  function automatic logic reg_match(logic [4:0] w, logic [4:0] rs, logic [4:0] rt,
                                     logic uses_rt);
    return (w != 5'd0) && ((w == rs) || (uses_rt && (w == rt)));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Opcode decode plus EX/MEM dependence check; yields required stall length.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [5:0] id_op,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_memread,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_wreg,
  input  logic       mem_memread,
  input  logic [4:0] mem_wreg,
  output logic [1:0] n_stall,
  output logic       is_branch,
  output logic       is_jump
);

  logic uses_rt, ex_hit, mem_hit;

  always_comb begin
    is_branch = (id_op == OP_BEQ) || (id_op == OP_BNE);
    is_jump   = (id_op == OP_J) || (id_op == OP_JAL);
    uses_rt   = (id_op == OP_RTYPE) || is_branch || (id_op == OP_SW);
    ex_hit    = reg_match(ex_wreg, id_rs, id_rt, uses_rt);
    mem_hit   = reg_match(mem_wreg, id_rs, id_rt, uses_rt);

    // Branches resolve in ID, so they also wait on ALU results and on loads in MEM.
    n_stall = 2'd0;
    if (ex_memread && ex_hit && is_branch)        n_stall = 2'd2;
    else if (ex_memread && ex_hit)                n_stall = 2'd1;
    else if (ex_regwrite && ex_hit && is_branch)  n_stall = 2'd1;
    else if (mem_memread && mem_hit && is_branch) n_stall = 2'd1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall sequencing FSM, Mealy pipeline controls, event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_branch_taken,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_wreg,
  input  logic             mem_memread,
  input  logic [4:0]       mem_wreg,
  input  logic             hold,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t     state;
  logic [1:0] left;
  logic [1:0] n_stall;
  logic       is_branch, is_jump;
  logic       stall_evt, flush_evt;

  hazard_detect u_detect (
    .id_op       (id_op),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_memread  (ex_memread),
    .ex_regwrite (ex_regwrite),
    .ex_wreg     (ex_wreg),
    .mem_memread (mem_memread),
    .mem_wreg    (mem_wreg),
    .n_stall     (n_stall),
    .is_branch   (is_branch),
    .is_jump     (is_jump)
  );

  always_comb begin
    stall_evt = !rst && !hold && ((state == STALL) || (n_stall != 2'd0));
    flush_evt = !rst && !hold && (state == RUN) && (n_stall == 2'd0) &&
                (is_jump || (is_branch && id_branch_taken));

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hold) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (stall_evt) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (flush_evt) begin
      ifid_flush  = 1'b1;
    end
  end

  // Only N=2 needs the STALL state; N=1 is fully covered by the detection cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      left      <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hold) begin
      case (state)
        RUN: if (n_stall == 2'd2) begin
          state <= STALL;
          left  <= 2'd1;
        end
        STALL: begin
          left <= left - 2'd1;
          if (left <= 2'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
  logic id_branch_taken, ex_memread, ex_regwrite, mem_memread, hold;
  logic pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: stall cycles still owed after the current one, and event tallies.
  int m_rem = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .id_branch_taken(id_branch_taken), .ex_memread(ex_memread),
    .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg), .mem_memread(mem_memread),
    .mem_wreg(mem_wreg), .hold(hold), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit depends(int w, int op) ;
    bit urt;
    urt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    return (w != 0) && ((w == id_rs) || (urt && (w == id_rt)));
  endfunction

  function automatic int need_stall();
    bit br;
    br = (id_op == 6'd4) || (id_op == 6'd5);
    if (ex_memread && depends(ex_wreg, id_op)) return br ? 2 : 1;
    if (br && ex_regwrite && depends(ex_wreg, id_op)) return 1;
    if (br && mem_memread && depends(mem_wreg, id_op)) return 1;
    return 0;
  endfunction

  task automatic drive(int op, int rs, int rt, bit tk, bit exm, bit exr, int exw,
                       bit mm, int mw, bit hd);
    id_op = 6'(op); id_rs = 5'(rs); id_rt = 5'(rt); id_branch_taken = tk;
    ex_memread = exm; ex_regwrite = exr; ex_wreg = 5'(exw);
    mem_memread = mm; mem_wreg = 5'(mw); hold = hd;
  endtask

  // One clock: check outputs mid-cycle, then advance the model as the edge will.
  task automatic cycle(string tag);
    logic [3:0] e;
    int kind, n;
    @(negedge clk);
    kind = 0;
    if (rst) begin
      m_rem = 0; m_stalls = 0; m_flushes = 0;
      e = 4'b0011;
    end else if (hold) begin
      e = 4'b0000;
    end else if (m_rem > 0) begin
      e = 4'b0001; kind = 1;
    end else begin
      n = need_stall();
      if (n > 0) begin
        e = 4'b0001; kind = 1;
      end else if (id_op == 6'd2 || id_op == 6'd3 ||
                   ((id_op == 6'd4 || id_op == 6'd5) && id_branch_taken)) begin
        e = 4'b1110; kind = 2;
      end else begin
        e = 4'b1100;
      end
    end
    chk({tag, ".ctl"}, {28'd0, pc_write, ifid_write, ifid_flush, idex_bubble}, {28'd0, e});
    chk({tag, ".scnt"}, 32'(stall_cnt), 32'(m_stalls));
    chk({tag, ".fcnt"}, 32'(flush_cnt), 32'(m_flushes));
    if (kind == 1) begin
      if (m_rem > 0) m_rem--; else m_rem = need_stall() - 1;
      if (m_stalls < CMAX) m_stalls++;
    end else if (kind == 2) begin
      if (m_flushes < CMAX) m_flushes++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle("rst");
    rst = 1'b0;
  endtask

  initial begin
    int ops[8] = '{0, 4, 5, 2, 3, 35, 43, 8};
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("reset");
    rst = 1'b0;

    // load-use through rs
    drive(0, 8, 2, 0, 1, 1, 8, 0, 0, 0);  cycle("lu_stall");
    drive(0, 8, 2, 0, 0, 0, 0, 1, 8, 0);  cycle("lu_adv");
    chk("lu_cnt", 32'(stall_cnt), 32'd1);

    // load-branch: two stalls, taken ignored in the second, then flush
    do_reset();
    drive(4, 9, 3, 0, 1, 1, 9, 0, 0, 0);  cycle("lb_s1");
    drive(4, 9, 3, 1, 1, 1, 9, 0, 0, 0);  cycle("lb_s2");
    drive(4, 9, 3, 1, 0, 0, 0, 0, 0, 0);  cycle("lb_flush");
    drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 0);  cycle("lb_adv");
    chk("lb_scnt", 32'(stall_cnt), 32'd2);
    chk("lb_fcnt", 32'(flush_cnt), 32'd1);

    // $0 never matches; addi does not read rt
    drive(0, 0, 0, 0, 1, 1, 0, 1, 0, 0);  cycle("zero_reg");
    drive(8, 1, 5, 0, 1, 1, 5, 0, 0, 0);  cycle("addi_rt");

    // jump flush is one cycle
    drive(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);  cycle("j_flush");
    drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 0);  cycle("j_adv");

    // hold on the first cycle of an N=2 stall
    drive(5, 9, 3, 0, 1, 1, 9, 0, 0, 1);  cycle("hold");
    drive(5, 9, 3, 0, 1, 1, 9, 0, 0, 0);  cycle("hold_s1");
    drive(5, 9, 3, 0, 1, 1, 9, 0, 0, 0);  cycle("hold_s2");
    drive(5, 9, 3, 0, 0, 0, 0, 0, 0, 0);  cycle("hold_adv");

    // reset during STALL, RUN after release
    drive(4, 9, 3, 0, 1, 1, 9, 0, 0, 0);  cycle("rs_s1");
    rst = 1'b1;                            cycle("rs_mid");
    rst = 1'b0;
    drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 0);  cycle("rs_run");

    // saturation of the stall counter
    do_reset();
    drive(0, 8, 2, 0, 1, 1, 8, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle("sat");
    chk("sat_cnt", 32'(stall_cnt), 32'(CMAX));

    // random traffic over a small register set to provoke matches
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
            1'($urandom), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
      cycle("rand");
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
